// File: rtl/btn_debounce_counter_if.sv
// Button/LED bundle for btn_debounce_counter: raw buttons in, counter value and press pulses out.
// The master side drives the raw buttons and the slave side (the debouncer) drives the results.
interface btn_debounce_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             BTN1;
    logic             BTN2;
    logic [WIDTH-1:0] leds;
    logic             btn1_pulse;
    logic             btn2_pulse;

    modport master (
        output BTN1,
        output BTN2,
        input  leds,
        input  btn1_pulse,
        input  btn2_pulse
    );

    modport slave (
        input  BTN1,
        input  BTN2,
        output leds,
        output btn1_pulse,
        output btn2_pulse
    );
endinterface

// File: rtl/btn_debounce_counter.sv
// Two-button synchronizer + debouncer driving a WIDTH-bit up/down LED counter.
// Optional macro COUNTER_SATURATE_EN: the counter saturates at its limits instead of wrapping.
module btn_debounce_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned WIDTH           = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    btn_debounce_counter_if.slave bus
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] StLow      = 2'd0;
    localparam logic [1:0] StRiseWait = 2'd1;
    localparam logic [1:0] StHigh     = 2'd2;
    localparam logic [1:0] StFallWait = 2'd3;

    logic [1:0]       w_raw;
    logic [1:0]       w_pulse_d;
    logic [1:0]       r_pulse;
    logic [WIDTH-1:0] r_leds;
    logic [WIDTH-1:0] w_leds_d;

    assign w_raw = {bus.BTN2, bus.BTN1};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic [1:0]             r_state;
        logic [1:0]             w_state_d;
        logic [CW-1:0]          r_cnt;
        logic [CW-1:0]          w_cnt_d;
        logic [CW-1:0]          w_cnt_inc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
            end
        end

        assign w_s       = r_sync[SYNC_STAGES-1];
        assign w_cnt_inc = r_cnt + CNT_ONE;

        // The sample that leaves LOW/HIGH is stable sample #1, so the level is accepted
        // on the DEBOUNCE_CYCLES-th consecutive sample (latency SYNC_STAGES + DEBOUNCE_CYCLES).
        always_comb begin
            w_state_d    = r_state;
            w_cnt_d      = r_cnt;
            w_pulse_d[b] = 1'b0;
            case (r_state)
                StLow: begin
                    if (w_s) begin
                        if (CNT_MAX == CNT_ONE) begin
                            w_state_d    = StHigh;
                            w_cnt_d      = '0;
                            w_pulse_d[b] = 1'b1;
                        end else begin
                            w_state_d = StRiseWait;
                            w_cnt_d   = CNT_ONE;
                        end
                    end
                end
                StRiseWait: begin
                    if (!w_s) begin
                        w_state_d = StLow;
                        w_cnt_d   = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_state_d    = StHigh;
                        w_cnt_d      = '0;
                        w_pulse_d[b] = 1'b1;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StHigh: begin
                    if (!w_s) begin
                        if (CNT_MAX == CNT_ONE) begin
                            w_state_d = StLow;
                            w_cnt_d   = '0;
                        end else begin
                            w_state_d = StFallWait;
                            w_cnt_d   = CNT_ONE;
                        end
                    end
                end
                StFallWait: begin
                    if (w_s) begin
                        w_state_d = StHigh;
                        w_cnt_d   = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_state_d = StLow;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_d = StLow;
                    w_cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= StLow;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_d;
                r_cnt   <= w_cnt_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_pulse_d;
        end
    end

    // Simultaneous pulses cancel out; the counter acts on the registered pulses.
    always_comb begin
        w_leds_d = r_leds;
        case (r_pulse)
            2'b01: begin
`ifdef COUNTER_SATURATE_EN
                if (r_leds != {WIDTH{1'b1}}) begin
                    w_leds_d = r_leds + 1'b1;
                end
`else
                w_leds_d = r_leds + 1'b1;
`endif
            end
            2'b10: begin
`ifdef COUNTER_SATURATE_EN
                if (r_leds != '0) begin
                    w_leds_d = r_leds - 1'b1;
                end
`else
                w_leds_d = r_leds - 1'b1;
`endif
            end
            default: w_leds_d = r_leds;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_leds_d;
        end
    end

    assign bus.leds       = r_leds;
    assign bus.btn1_pulse = r_pulse[0];
    assign bus.btn2_pulse = r_pulse[1];

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Self-checking bench for btn_debounce_counter: directed scenarios plus random button/reset
// stimulus, compared every cycle against a run-length behavioural model.
module tb_btn_debounce_counter;

    localparam int unsigned D    = 4;
    localparam int unsigned S    = 2;
    localparam int unsigned W    = 4;
    localparam int          MAXV = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    btn_debounce_counter_if #(.WIDTH(W)) bus ();

    btn_debounce_counter #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S),
        .WIDTH          (W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int p1_cnt = 0;
    int p2_cnt = 0;

    // Behavioural model: raw input delayed S edges, level flips after D consecutive
    // samples that disagree with it, counter follows the previous cycle's pulses.
    bit [S-1:0] m_dly   [2];
    bit         m_lvl   [2];
    int         m_run   [2];
    bit         m_pulse [2];
    int         m_leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_dly[b]   = '0;
            m_lvl[b]   = 1'b0;
            m_run[b]   = 0;
            m_pulse[b] = 1'b0;
        end
        m_leds = 0;
    endtask

    task automatic model_step();
        bit raw [2];
        bit s;
        raw[0] = bus.BTN1;
        raw[1] = bus.BTN2;
        if (m_pulse[0] && !m_pulse[1]) begin
`ifdef COUNTER_SATURATE_EN
            if (m_leds != MAXV) m_leds = m_leds + 1;
`else
            m_leds = (m_leds + 1) % (MAXV + 1);
`endif
        end else if (m_pulse[1] && !m_pulse[0]) begin
`ifdef COUNTER_SATURATE_EN
            if (m_leds != 0) m_leds = m_leds - 1;
`else
            m_leds = (m_leds + MAXV) % (MAXV + 1);
`endif
        end
        for (int b = 0; b < 2; b++) begin
            s          = m_dly[b][S-1];
            m_pulse[b] = 1'b0;
            if (s != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_lvl[b]   = s;
                    m_run[b]   = 0;
                    m_pulse[b] = s;
                end
            end else begin
                m_run[b] = 0;
            end
            m_dly[b] = {m_dly[b][S-2:0], raw[b]};
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_leds", bus.leds, m_leds);
            check("model_pulse1", bus.btn1_pulse, m_pulse[0]);
            check("model_pulse2", bus.btn2_pulse, m_pulse[1]);
            if (bus.btn1_pulse === 1'b1) p1_cnt++;
            if (bus.btn2_pulse === 1'b1) p2_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic edges_to_pulse(input int which, output int n);
        bit hit;
        hit = 1'b0;
        n   = -1;
        for (int i = 1; i <= 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            if ((which == 1 ? bus.btn1_pulse : bus.btn2_pulse) === 1'b1) begin
                hit = 1'b1;
                n   = i;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input int which, input int hold);
        @(negedge clk);
        if (which == 1) bus.BTN1 = 1'b1;
        else            bus.BTN2 = 1'b1;
        repeat (hold) @(negedge clk);
        if (which == 1) bus.BTN1 = 1'b0;
        else            bus.BTN2 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    int n;
    int p_before;

    initial begin
        bus.BTN1 = 1'b1;
        bus.BTN2 = 1'b0;

        // Reset held with BTN1 high, then released.
        repeat (3) @(negedge clk);
        check("reset_leds", bus.leds, 0);
        check("reset_pulse1", bus.btn1_pulse, 0);
        rst_n = 1'b1;
        edges_to_pulse(1, n);
        check("release_latency", n, 6);
        @(posedge clk);
        #1;
        check("release_leds", bus.leds, 1);
        @(negedge clk);
        bus.BTN1 = 1'b0;
        repeat (10) @(negedge clk);

        // Bounce rejection.
        p_before = p1_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.BTN1 = ((i % 4) < 2);
        end
        @(negedge clk);
        check("bounce_no_pulse", p1_cnt, p_before);
        bus.BTN1 = 1'b1;
        edges_to_pulse(1, n);
        check("bounce_latency", n, 6);
        @(posedge clk);
        #1;
        check("bounce_leds", bus.leds, 2);
        @(negedge clk);
        bus.BTN1 = 1'b0;
        repeat (10) @(negedge clk);

        // Decrement from zero.
        do_reset();
        check("dec_start", bus.leds, 0);
        p_before = p2_cnt;
        press(2, 10);
`ifdef COUNTER_SATURATE_EN
        check("dec_wrap", bus.leds, 0);
`else
        check("dec_wrap", bus.leds, 15);
`endif
        check("dec_pulses", p2_cnt - p_before, 1);

        // Sixteen long presses.
        do_reset();
        p_before = p1_cnt;
        for (int i = 0; i < 16; i++) press(1, 50);
`ifdef COUNTER_SATURATE_EN
        check("inc_wrap", bus.leds, 15);
`else
        check("inc_wrap", bus.leds, 0);
`endif
        check("inc_pulses", p1_cnt - p_before, 16);

        // Simultaneous presses from 5.
        do_reset();
        for (int i = 0; i < 5; i++) press(1, 8);
        check("simul_start", bus.leds, 5);
        @(negedge clk);
        bus.BTN1 = 1'b1;
        bus.BTN2 = 1'b1;
        edges_to_pulse(1, n);
        check("simul_latency", n, 6);
        check("simul_pulse2", bus.btn2_pulse, 1);
        @(posedge clk);
        #1;
        check("simul_leds", bus.leds, 5);
        @(negedge clk);
        bus.BTN1 = 1'b0;
        bus.BTN2 = 1'b0;
        repeat (10) @(negedge clk);

        // Asynchronous reset during RISE_WAIT.
        do_reset();
        for (int i = 0; i < 7; i++) press(1, 8);
        check("midrst_start", bus.leds, 7);
        @(negedge clk);
        bus.BTN1 = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_leds", bus.leds, 0);
        check("midrst_pulse1", bus.btn1_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges_to_pulse(1, n);
        check("midrst_latency", n, 6);
        @(posedge clk);
        #1;
        check("midrst_leds_after", bus.leds, 1);
        @(negedge clk);
        bus.BTN1 = 1'b0;
        repeat (10) @(negedge clk);

        // Random buttons with occasional asynchronous resets.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) bus.BTN1 = ~bus.BTN1;
            if ($urandom_range(0, 2) == 0) bus.BTN2 = ~bus.BTN2;
            repeat ($urandom_range(0, 10)) @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                #3;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
